// File: rtl/clef_pkg.sv
// Shared constants for the treble-clef sprite renderer.
// Sprite geometry, ROM latency and the out-of-box address.
package clef_pkg;
  localparam int CLEF_W    = 40;
  localparam int CLEF_H    = 80;
  localparam int CLEF_SIZE = CLEF_W * CLEF_H;
  localparam int ROM_LAT   = 2;
  localparam int ADDR_W    = 14;
  localparam logic [ADDR_W-1:0] OOB_ADDR = 14'h3FFF;
endpackage

// File: rtl/sig_delay.sv
// Resettable shift-register delay line.
// Output is the input delayed by DEPTH clock cycles.
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];
endmodule

// File: rtl/clef_sprite_renderer.sv
// Treble-clef sprite address generator and pixel compositor.
// Addresses come from counters; syncs are delayed to match the ROM pixel.
module clef_sprite_renderer
  import clef_pkg::*;
#(
  parameter int         H_ACTIVE = 640,
  parameter int         V_ACTIVE = 480,
  parameter int         SCALE    = 1,
  parameter logic [2:0] FG_RGB   = 3'b000,
  parameter logic [2:0] BG_RGB   = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              enable,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              treble_in,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [2:0]        rgb
);
  localparam int BOX_W = CLEF_W * SCALE;
  localparam int BOX_H = CLEF_H * SCALE;

  logic [9:0]  pos_x_q, pos_y_q;
  logic        enable_q;
  logic [11:0] row_base, row_c;
  logic [5:0]  col, col_c;
  logic [1:0]  hsub, hsub_c, vsub, vsub_c;
  logic [10:0] x_end, y_end;
  logic        frame_start, line_start;
  logic        in_box, line_last;
  logic [3:0]  dly_q;

  assign x_end = {1'b0, pos_x_q} + 11'(BOX_W);
  assign y_end = {1'b0, pos_y_q} + 11'(BOX_H);

  assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);
  assign line_start  = (hcount == pos_x_q);

  assign in_box = enable_q && video_on
    && (hcount >= pos_x_q) && ({1'b0, hcount} < x_end)
    && (vcount >= pos_y_q) && ({1'b0, vcount} < y_end)
    && (hcount < 10'(H_ACTIVE))
    && (vcount < 10'(V_ACTIVE));

  // Right-edge clipping makes the last visible column end the box line.
  assign line_last = in_box
    && (({1'b0, hcount} == x_end - 11'd1)
     || (hcount == 10'(H_ACTIVE - 1)));

  assign row_c  = frame_start ? '0 : row_base;
  assign vsub_c = frame_start ? '0 : vsub;
  assign col_c  = (frame_start || line_start) ? '0 : col;
  assign hsub_c = (frame_start || line_start) ? '0 : hsub;

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= OOB_ADDR;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      enable_q <= 1'b0;
      row_base <= '0;
      col      <= '0;
      hsub     <= '0;
      vsub     <= '0;
    end else begin
      rom_addr <= in_box
        ? ADDR_W'(row_c) + ADDR_W'(col_c)
        : OOB_ADDR;
      if (frame_start) begin
        pos_x_q  <= pos_x;
        pos_y_q  <= pos_y;
        enable_q <= enable;
      end
      col  <= col_c;
      hsub <= hsub_c;
      if (in_box) begin
        if (hsub_c == 2'(SCALE - 1)) begin
          hsub <= '0;
          col  <= col_c + 6'd1;
        end else begin
          hsub <= hsub_c + 2'd1;
        end
      end
      row_base <= row_c;
      vsub     <= vsub_c;
      if (line_last) begin
        if (vsub_c == 2'(SCALE - 1)) begin
          vsub     <= '0;
          row_base <= row_c + 12'(CLEF_W);
        end else begin
          vsub <= vsub_c + 2'd1;
        end
      end
    end
  end

  sig_delay #(
    .WIDTH(4),
    .DEPTH(ROM_LAT + 1)
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .d    ({video_on, in_box, hsync_in, vsync_in}),
    .q    (dly_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb       <= 3'b000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      rgb <= !dly_q[3] ? 3'b000
           : (dly_q[2] && treble_in) ? FG_RGB
           : BG_RGB;
      hsync_out <= dly_q[1];
      vsync_out <= dly_q[0];
    end
  end
endmodule
